// File: rtl/sqrt_iter_hs.sv
// sqrt_iter_hs: iterative unsigned integer square root, one root bit per clock.
// Operand side and result side are both valid/ready handshakes. A new operand
// can be accepted on the same edge that retires the previous result.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o operand handshake (in_ready_o is combinational)
//   x_i, round_i          operand and rounding mode (0 floor, 1 nearest)
//   out_valid_o/out_ready_i result handshake, results held under backpressure
//   root_o                root; MSB only set by round-to-nearest overflow
//   rem_o                 x - floor_root^2, independent of rounding mode
//   exact_o               rem_o == 0
// W must be even and at least 4.
module sqrt_iter_hs #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [W-1:0]   x_i,
  input  logic           round_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W/2:0]   root_o,
  output logic [W/2:0]   rem_o,
  output logic           exact_o
);

  localparam int unsigned R  = W / 2;
  localparam int unsigned CW = $clog2(R + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [W-1:0]   x_q;
  logic           round_q;
  logic [R-1:0]   root_acc;
  logic [R+1:0]   rem_acc;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic [R+1:0]   rem_sh;
  logic [R+1:0]   trial;
  logic           ge;
  logic [R+1:0]   rem_nx;
  logic [R-1:0]   root_nx;
  logic           rnd_up;

  // Ready in IDLE, or in DONE when the current result is being consumed.
  assign in_ready_o = (state == IDLE) || ((state == DONE) && out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // One restoring-sqrt step: bring down the next operand bit pair (MSB first).
  always_comb begin
    rem_sh  = (R+2)'({rem_acc, x_q[W-1 -: 2]});
    trial   = {root_acc, 2'b01};
    ge      = (rem_sh >= trial);
    rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    root_nx = R'({root_acc, ge});
    // Round up when x > r^2 + r, i.e. x lies past (r + 0.5)^2.
    rnd_up  = round_q && (rem_nx > (R+2)'(root_nx));
  end

  // Control, datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_q         <= '0;
      round_q     <= 1'b0;
      root_acc    <= '0;
      rem_acc     <= '0;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      root_o      <= '0;
      rem_o       <= '0;
      exact_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q      <= x_i;
            round_q  <= round_i;
            root_acc <= '0;
            rem_acc  <= '0;
            cnt      <= CW'(R);
            state    <= CALC;
          end
        end
        CALC: begin
          x_q      <= {x_q[W-3:0], 2'b00};
          root_acc <= root_nx;
          rem_acc  <= rem_nx;
          cnt      <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            root_o      <= (R+1)'({1'b0, root_nx}) + (R+1)'(rnd_up);
            rem_o       <= rem_nx[R:0];
            exact_o     <= (rem_nx == '0);
            out_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            if (accept) begin
              x_q      <= x_i;
              round_q  <= round_i;
              root_acc <= '0;
              rem_acc  <= '0;
              cnt      <= CW'(R);
              state    <= CALC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_hs.sv
// Bench for sqrt_iter_hs: W=16 and W=32 instances checked against a plain
// arithmetic square-root model (binary search on r*r <= x).
module tb_sqrt_iter_hs;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // W=16 instance
  logic        v16, irdy16, r16, ov16, ordy16, ex16;
  logic [15:0] x16;
  logic [8:0]  rt16, rm16;
  // W=32 instance
  logic        v32, irdy32, r32, ov32, ordy32, ex32;
  logic [31:0] x32;
  logic [16:0] rt32, rm32;

  sqrt_iter_hs #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v16), .in_ready_o(irdy16),
    .x_i(x16), .round_i(r16), .out_valid_o(ov16), .out_ready_i(ordy16),
    .root_o(rt16), .rem_o(rm16), .exact_o(ex16));

  sqrt_iter_hs #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v32), .in_ready_o(irdy32),
    .x_i(x32), .round_i(r32), .out_valid_o(ov32), .out_ready_i(ordy32),
    .root_o(rt32), .rem_o(rm32), .exact_o(ex32));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: largest r with r*r <= x, then optional round-to-nearest.
  task automatic ref_sqrt(input longint x, input bit rnd,
                          output longint root, output longint rem, output longint ex);
    longint lo, hi, mid;
    lo = 0;
    hi = 131072;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    rem  = x - lo * lo;
    root = lo + ((rnd && rem > lo) ? 1 : 0);
    ex   = (rem == 0) ? 1 : 0;
  endtask

  // Single operation from IDLE; returns outputs and cycles from accept to valid.
  task automatic run_op(input bit w32, input longint x, input bit rnd,
                        output longint root, output longint rem, output longint ex,
                        output int lat);
    if (w32) begin v32 = 1'b1; x32 = 32'(x); r32 = rnd; end
    else     begin v16 = 1'b1; x16 = 16'(x); r16 = rnd; end
    @(posedge clk); #1;
    v16 = 1'b0; v32 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(w32 ? ov32 : ov16) && lat < 100);
    root = w32 ? longint'(rt32) : longint'(rt16);
    rem  = w32 ? longint'(rm32) : longint'(rm16);
    ex   = w32 ? longint'(ex32) : longint'(ex16);
    if (w32) ordy32 = 1'b1; else ordy16 = 1'b1;
    @(posedge clk); #1;
    check("retire_valid_low", w32 ? longint'(ov32) : longint'(ov16), 0);
    ordy16 = 1'b0; ordy32 = 1'b0;
  endtask

  typedef struct { longint root; longint rem; longint ex; } res_t;
  res_t   q[$];
  res_t   e;
  longint eroot, erem, eex, groot, grem, gex;
  longint hroot, hrem, hex;
  int     lat, cyc, prev, accepted;
  bit     acc;

  longint dx16 [6] = '{65535, 65535, 0, 144, 3, 2};
  bit     dr16 [6] = '{0, 1, 0, 0, 1, 1};

  initial begin
    rst_n = 1'b0;
    v16 = 0; x16 = '0; r16 = 0; ordy16 = 0;
    v32 = 0; x32 = '0; r32 = 0; ordy32 = 0;
    #12;
    check("rst_in_ready16", irdy16, 1);
    check("rst_out_valid16", ov16, 0);
    check("rst_root16", rt16, 0);
    check("rst_rem16", rm16, 0);
    check("rst_exact16", ex16, 0);
    check("rst_out_valid32", ov32, 0);
    check("rst_root32", rt32, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed and random W=16 operations
    for (int i = 0; i < 16; i++) begin
      longint x;
      bit rnd;
      if (i < 6) begin x = dx16[i]; rnd = dr16[i]; end
      else begin x = longint'($urandom_range(65535)); rnd = 1'($urandom_range(1)); end
      ref_sqrt(x, rnd, eroot, erem, eex);
      run_op(1'b0, x, rnd, groot, grem, gex, lat);
      check("w16_root", groot, eroot);
      check("w16_rem", grem, erem);
      check("w16_exact", gex, eex);
      check("w16_latency", lat, 8);
    end

    // W=32 operations, including the all-ones operand in both modes
    for (int i = 0; i < 8; i++) begin
      longint x;
      bit rnd;
      if (i < 2) begin x = 64'hFFFF_FFFF; rnd = 1'(i); end
      else begin x = longint'($urandom); rnd = 1'($urandom_range(1)); end
      ref_sqrt(x, rnd, eroot, erem, eex);
      run_op(1'b1, x, rnd, groot, grem, gex, lat);
      check("w32_root", groot, eroot);
      check("w32_rem", grem, erem);
      check("w32_exact", gex, eex);
      check("w32_latency", lat, 16);
    end

    // Backpressure, with in_valid held high during CALC and DONE
    begin
      longint x;
      bit rnd;
      x = longint'($urandom_range(65535));
      rnd = 1'($urandom_range(1));
      ref_sqrt(x, rnd, eroot, erem, eex);
      v16 = 1'b1; x16 = 16'(x); r16 = rnd;
      @(posedge clk); #1;
      cyc = 0;
      while (!ov16 && cyc < 100) begin
        check("bp_calc_in_ready", irdy16, 0);
        x16 = 16'($urandom);
        r16 = ~rnd;
        @(posedge clk); #1;
        cyc++;
      end
      check("bp_latency", cyc, 8);
      check("bp_root", rt16, eroot);
      check("bp_rem", rm16, erem);
      hroot = rt16; hrem = rm16; hex = ex16;
      for (int i = 0; i < 5; i++) begin
        v16 = 1'(i % 2);
        x16 = 16'($urandom);
        @(posedge clk); #1;
        check("bp_valid_held", ov16, 1);
        check("bp_in_ready", irdy16, 0);
        check("bp_root_stable", rt16, hroot);
        check("bp_rem_stable", rm16, hrem);
        check("bp_exact_stable", ex16, hex);
      end
      v16 = 1'b0;
      ordy16 = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_fall", ov16, 0);
      check("bp_idle_ready", irdy16, 1);
      ordy16 = 1'b0;
    end

    // Back-to-back stream
    ordy16 = 1'b1;
    v16 = 1'b1;
    x16 = 16'($urandom);
    r16 = 1'($urandom_range(1));
    accepted = 0;
    prev = -1;
    cyc = 0;
    while ((accepted < 200 || q.size() > 0) && cyc < 5000) begin
      if (ov16) begin
        if (q.size() == 0) check("b2b_spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          check("b2b_root", rt16, e.root);
          check("b2b_rem", rm16, e.rem);
          check("b2b_exact", ex16, e.ex);
          if (prev >= 0) check("b2b_gap", cyc - prev, 9);
          prev = cyc;
        end
      end
      acc = v16 && irdy16;
      if (acc) begin
        ref_sqrt(longint'(x16), r16, e.root, e.rem, e.ex);
        q.push_back(e);
        accepted++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (accepted == 200) v16 = 1'b0;
        else begin
          x16 = 16'($urandom);
          r16 = 1'($urandom_range(1));
        end
      end
    end
    check("b2b_drained", q.size(), 0);
    check("b2b_accepted", accepted, 200);
    ordy16 = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of CALC, then a clean operation
    begin
      longint x;
      x = longint'($urandom_range(65535));
      run_op(1'b0, x, 1'b0, groot, grem, gex, lat);
      v16 = 1'b1; x16 = 16'd50000; r16 = 1'b1;
      @(posedge clk); #1;
      v16 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", irdy16, 1);
      check("midrst_out_valid", ov16, 0);
      check("midrst_root", rt16, 0);
      check("midrst_rem", rm16, 0);
      check("midrst_exact", ex16, 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      x = 12345;
      ref_sqrt(x, 1'b1, eroot, erem, eex);
      run_op(1'b0, x, 1'b1, groot, grem, gex, lat);
      check("postrst_root", groot, eroot);
      check("postrst_rem", grem, erem);
      check("postrst_latency", lat, 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
